// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default baud divisor, FSM state types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200, shared by both link ends

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: recovers bytes from the rx pin, strobes valid or frame_err.
// Latency: strobe 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start edge at the pin.
// Backpressure: none; the consumer must take data in the valid cycle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BI_W = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0]   BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BI_W-1:0] LAST_BIT    = BI_W'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t            state_d, state_q;
    logic [CW-1:0]             baud_d, baud_q;
    logic [BI_W-1:0]           bit_idx_d, bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_d, shift_q;
    logic [UART_DATA_BITS-1:0] data_d, data_q;
    logic                      valid_d, valid_q;
    logic                      ferr_d, ferr_q;
    logic                      busy_d, busy_q;
    logic                      baud_zero;

    sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign baud_zero = (baud_q == '0);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    bit_idx_d = '0;
                    baud_d    = HALF_RELOAD;
                    state_d   = RX_START;
                end
            end
            RX_START: begin
                if (baud_zero) begin
                    baud_d  = BIT_RELOAD;
                    // A start bit that is high again at mid-bit was only a glitch
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_zero) begin
                    baud_d             = BIT_RELOAD;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_zero) begin
                    baud_d = BIT_RELOAD;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_BREAK;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            RX_BREAK: begin
                // Hold off until the line returns high so a break is not seen as 0x00 frames
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        busy_d = (state_d != RX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial TX model drives rx, a monitor logs strobes,
// and each frame is checked for kind, byte value, strobe latency and data hold.
module tb_uart_rx;

    localparam int N   = 16;
    localparam int LAT = 1 + 2 + 8 + 9 * N;

    localparam int K_VALID = 1;
    localparam int K_FERR  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] dat;
        int         cyc;
    } ev_t;

    ev_t evq[$];
    int  both_hi   = 0;
    int  busy_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid || frame_err)
                evq.push_back('{kind: (valid ? K_VALID : K_FERR), dat: data, cyc: cyc});
            if (valid && frame_err) both_hi++;
            if (busy) busy_seen = 1;
        end
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name, input int lat);
        n_vec++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            n_err++;
            $display("FAIL %s: strobe latency %0d, expected %0d +/-1", name, lat, LAT);
        end
    endtask

    // Every drive starts just after a rising edge and ends just after one
    task automatic hold(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, output int start_cyc);
        start_cyc = cyc;
        hold(1'b0, N);
        for (int i = 0; i < 8; i++) hold(b[i], N);
        hold(stop, N);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] b, input int sc, input string tag);
        ev_t e;
        if (evq.size() == 0) begin
            chk({tag, " strobe present"}, 32'd0, 32'd1);
            return;
        end
        e = evq.pop_front();
        chk({tag, " kind"}, e.kind, kind);
        if (kind == K_VALID) begin
            chk({tag, " data"}, e.dat, b);
            last_good = b;
        end
        chk_lat({tag, " latency"}, e.cyc - sc);
        chk({tag, " data held"}, data, last_good);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop_ok;
        int         hold_low;
        int         gap_bits;
        int         exp_kind;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t tbl[7];
    int   sc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'hAD, 1'b1,  0, 2, K_VALID, 8'hAD};
        tbl[1] = '{8'hBC, 1'b1,  0, 0, K_VALID, 8'hBC};
        tbl[2] = '{8'hFF, 1'b1,  0, 0, K_VALID, 8'hFF};
        tbl[3] = '{8'h00, 1'b1,  0, 0, K_VALID, 8'h00};
        tbl[4] = '{8'h81, 1'b1,  0, 2, K_VALID, 8'h81};
        tbl[5] = '{8'h55, 1'b0, 40, 2, K_FERR,  8'h00};
        tbl[6] = '{8'h3C, 1'b1,  0, 2, K_VALID, 8'h3C};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data", data, 8'h00);
        chk("reset valid", valid, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;

        busy_seen = 0;
        hold(1'b1, 500);
        chk("idle busy seen", busy_seen, 0);
        chk("idle strobes", evq.size(), 0);
        chk("idle data", data, 8'h00);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].b, tbl[i].stop_ok, sc);
            expect_ev(tbl[i].exp_kind, tbl[i].exp_dat, sc, $sformatf("vec%0d", i));
            if (tbl[i].hold_low > 0) begin
                hold(1'b0, tbl[i].hold_low);
                chk($sformatf("vec%0d busy in break", i), busy, 1'b1);
                chk($sformatf("vec%0d no strobe in break", i), evq.size(), 0);
            end
            hold(1'b1, tbl[i].gap_bits * N);
        end

        busy_seen = 0;
        hold(1'b0, 4);
        hold(1'b1, 3 * N);
        chk("glitch busy pulsed", busy_seen, 1);
        chk("glitch busy back low", busy, 1'b0);
        chk("glitch strobes", evq.size(), 0);
        chk("glitch data held", data, last_good);

        // Reset in the middle of data bit 4 of 0xA5
        hold(1'b0, N);
        for (int i = 0; i < 4; i++) hold(8'hA5 >> i, N);
        hold(1'b0, N / 2);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_good = 8'h00;
        chk("mid-frame reset busy", busy, 1'b0);
        chk("mid-frame reset data", data, 8'h00);
        hold(1'b1, 2 * N);
        chk("mid-frame reset strobes", evq.size(), 0);
        send(8'h5A, 1'b1, sc);
        expect_ev(K_VALID, 8'h5A, sc, "after reset");
        hold(1'b1, N);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            logic       ok;
            int         gap;
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2);
            send(b, ok, sc);
            expect_ev(ok ? K_VALID : K_FERR, b, sc, $sformatf("rand%0d", i));
            if (!ok) begin
                hold(1'b0, $urandom_range(0, 30));
                gap = gap + 1;
            end
            hold(1'b1, gap * N);
        end

        hold(1'b1, 2 * N);
        chk("no stray strobes", evq.size(), 0);
        chk("valid and frame_err together", both_hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART datapath: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from the asynchronous `rx` line and presents each byte as a one-cycle strobe to the byte consumer. It is the receiving end of the link whose transmit side drives the same frame format. It sits between the board RX pin and the parallel 8-bit byte interface used by the rest of the design.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200); legal range 4..65535.

Ports:
- `clk` in 1: single system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial line; idle high.
- `data` out 8: last correctly received byte; holds until the next good frame.
- `valid` out 1: one-cycle strobe; `data` is new in the same cycle.
- `frame_err` out 1: one-cycle strobe; stop bit sampled low.
- `busy` out 1: high whenever the FSM is not IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when `rx_s` = 0, clear the bit counter, load baud counter, and go to START.
- START: wait `CLKS_PER_BIT/2` cycles (integer division), then sample `rx_s`.
  - If 0, go to DATA.
  - If 1, treat as a glitch: return to IDLE with no strobe.
- DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit position `bit_idx`, LSB first. After 8 samples, go to STOP.
- STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
  - If 1: `data` ← shift register, pulse `valid`, go to IDLE.
  - If 0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
- BREAK: wait until `rx_s` = 1, then go to IDLE. This prevents a held-low line or break condition from being decoded as 0x00 frames.
- Baud counter: width is `$clog2(CLKS_PER_BIT)`. It counts down to 0, then reloads `CLKS_PER_BIT-1`; the sample is taken in the cycle the count is 0.
- A start edge is accepted on the cycle after a STOP→IDLE transition. Back-to-back frames with no idle gap are received without loss.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `data` = 8'h00, `valid` = 0, `frame_err` = 0, `busy` = 0, state IDLE, synchronizer flops = 1 (idle line).
- `rst` asserted mid-frame: the frame is abandoned on the next edge and no strobe is issued. After reset is released, a line that is still low is taken as a new start bit.
- Synchronizer latency is 2 cycles.
- From the synchronized falling edge to the stop-bit sample: `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles.
- `valid` / `frame_err` are registered and assert 1 cycle after the stop sample.
- Sample points land within ±1 clock of bit centers. Tolerable baud mismatch is about ±4% at default settings.
- No backpressure: the consumer must accept `valid` in the cycle it is high. `data` remains stable until the next `valid`.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state enum `uart_rx_state_t` (the TX side defines its own in the same package).
  - `UART_DATA_BITS` = 8.
  - Default `CLKS_PER_BIT` constant, shared with the transmitter so both ends agree.
- Sub-module `sync2`: generic 2-flop synchronizer with a reset-value parameter. It is reused for other async inputs such as buttons.
- FSM, baud counter, bit counter and shift register stay in `uart_rx`. Expected size is about 150–200 lines.

## Test plan
All tests use `CLKS_PER_BIT` = 16, with a bench TX model driving `rx`.
- Reset then idle line for 500 cycles → `data` = 0x00; `valid`, `frame_err` and `busy` stay 0 throughout.
- Send 0xAD, then 0xBC with 2 idle bits between → two `valid` pulses, `data` = 0xAD then 0xBC. Each strobe falls 1 + 2 + 8 + 9×16 cycles after the start edge at the pin, ±1.
- 4-cycle low glitch on idle line → `busy` high briefly, returns to IDLE, no strobe, `data` unchanged.
- Send 0x55 with the stop bit forced low, then hold low 40 cycles, then release and send 0x3C → one `frame_err` pulse, no `valid` for 0x55, FSM waits in BREAK, then `valid` with 0x3C.
- Send 0xFF, 0x00, 0x81 back-to-back (stop bit immediately followed by start) → three `valid` pulses with exact values.
- Assert `rst` for 1 cycle in the middle of data bit 4 of 0xA5 → no strobe; `busy` = 0 after reset; next frame 0x5A is received correctly.
